pe_psum_acc: RTL and testbench

Partial-sum accumulation stage sitting directly downstream of the PE adder tree. Each cycle the tree delivers one 32-bit sum of 32 products (one vector chunk). This block accumulates a programmed number of such chunks, starting from a bias value, into one dot-product result. It presents that result on a valid/ready output port. It is the sequential tail of the PE and turns the tree's per-chunk sums into full-length dot products for the output buffer.

---
 rtl/pe_pkg.sv | 6 +
 rtl/pe_psum_acc_if.sv | 24 ++
 rtl/pe_psum_acc.sv | 45 ++++
 tb/tb_pe_psum_acc.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared PE constants and the psum accumulator state encoding
package pe_pkg;
  localparam int PE_DATA_W = 32;
  localparam int PE_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/pe_psum_acc_if.sv
// pe_psum_acc_if: job (start/chunk_num/bias), chunk input (in_valid/in_ready/in_data), result output (out_valid/out_ready/out_data) and busy
interface pe_psum_acc_if #(
  parameter int DATA_W = pe_pkg::PE_DATA_W,
  parameter int CNT_W = pe_pkg::PE_CNT_W
);
  logic start;
  logic [CNT_W-1:0] chunk_num;
  logic [DATA_W-1:0] bias;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic busy;
  modport master (
    output start, chunk_num, bias, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, busy
  );
  modport slave (
    input start, chunk_num, bias, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pe_psum_acc.sv
// pe_psum_acc: accumulates chunk_num+1 chunk sums onto bias; ports clk, rst (async high), s (pe_psum_acc_if.slave)
module pe_psum_acc
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int CNT_W = PE_CNT_W
) (
  input logic clk,
  input logic rst,
  pe_psum_acc_if.slave s
);
  state_t state_q;
  logic [DATA_W-1:0] acc_q, acc_d, out_q;
  logic [CNT_W-1:0] rem_q;
  assign acc_d = acc_q + s.in_data;
  assign s.in_ready = state_q == ACC;
  assign s.out_valid = state_q == DONE;
  assign s.busy = state_q != IDLE;
  assign s.out_data = out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      rem_q <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (s.start) begin
          acc_q <= s.bias;
          rem_q <= s.chunk_num;
          state_q <= ACC;
        end
        ACC: if (s.in_valid) begin
          acc_q <= acc_d;
          if (rem_q == '0) begin
            out_q <= acc_d;
            state_q <= DONE;
          end else rem_q <= rem_q - 1'b1;
        end
        DONE: if (s.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_psum_acc.sv
// tb_pe_psum_acc: directed self-checking bench for pe_psum_acc
module tb_pe_psum_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  pe_psum_acc_if b ();
  pe_psum_acc dut (.clk(clk), .rst(rst), .s(b));
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    b.start = 1'b0; b.chunk_num = '0; b.bias = '0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
  endtask
  task automatic kick(input logic [7:0] cn, input logic [31:0] bs);
    b.start = 1'b1; b.chunk_num = cn; b.bias = bs;
    step();
    b.start = 1'b0;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    total++; if (b.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h want=0", b.in_ready); end
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h want=0", b.out_valid); end
    total++; if (b.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%0h want=0", b.out_data); end
    total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", b.busy); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_single();
    kick(8'd0, 32'd5);
    total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%0h want=1", b.in_ready); end
    total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h want=1", b.busy); end
    b.in_valid = 1'b1; b.in_data = 32'd10;
    step();
    b.in_valid = 1'b0;
    total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%0h want=1", b.out_valid); end
    total++; if (b.out_data !== 32'd15) begin bad++; $display("FAIL single_out_data got=%0h want=f", b.out_data); end
    total++; if (b.in_ready !== 1'b0) begin bad++; $display("FAIL single_done_in_ready got=%0h want=0", b.in_ready); end
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%0h want=0", b.out_valid); end
    total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0h want=0", b.busy); end
  endtask
  task automatic test_back_to_back();
    int cyc;
    kick(8'd3, 32'd0);
    cyc = 1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0h want=0 chunk=%0d", b.out_valid, i); end
      b.in_valid = 1'b1; b.in_data = 32'(i);
      step();
      cyc++;
    end
    b.in_valid = 1'b0;
    total++; if (cyc !== 5) begin bad++; $display("FAIL b2b_latency got=%0d want=5", cyc); end
    total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid got=%0h want=1", b.out_valid); end
    total++; if (b.out_data !== 32'd10) begin bad++; $display("FAIL b2b_out_data got=%0h want=a", b.out_data); end
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
  endtask
  task automatic test_gapped();
    logic [31:0] chunks [3];
    chunks[0] = 32'd100; chunks[1] = -32'sd50; chunks[2] = 32'd7;
    kick(8'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      b.in_valid = 1'b1; b.in_data = chunks[i];
      step();
      b.in_valid = 1'b0; b.in_data = 32'hdead_beef;
      if (i < 2) begin
        step();
        total++; if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin bad++; $display("FAIL gap_hold got=%0h%0h want=10 gap=%0d", b.in_ready, b.out_valid, i); end
        step();
      end
    end
    total++; if (b.out_data !== 32'd57) begin bad++; $display("FAIL gap_out_data got=%0h want=39", b.out_data); end
    for (int i = 0; i < 4; i++) begin
      b.start = (i == 1); b.chunk_num = 8'd0; b.bias = 32'd999;
      b.in_valid = 1'b1; b.in_data = 32'd1;
      step();
      total++; if (b.out_valid !== 1'b1 || b.out_data !== 32'd57 || b.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stable got v=%0h d=%0h r=%0h want v=1 d=39 r=0", b.out_valid, b.out_data, b.in_ready); end
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1; b.start = 1'b1;
    step();
    b.out_ready = 1'b0; b.start = 1'b0;
    total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL handshake_start_busy got=%0h want=0", b.busy); end
    b.in_valid = 1'b1;
    step();
    b.in_valid = 1'b0;
    total++; if (b.busy !== 1'b0 || b.out_data !== 32'd57) begin bad++; $display("FAIL idle_ignore got busy=%0h d=%0h want busy=0 d=39", b.busy, b.out_data); end
  endtask
  task automatic test_wrap();
    kick(8'd0, 32'h7fff_ffff);
    b.in_valid = 1'b1; b.in_data = 32'd1;
    step();
    b.in_valid = 1'b0;
    total++; if (b.out_data !== 32'h8000_0000) begin bad++; $display("FAIL wrap_out_data got=%0h want=80000000", b.out_data); end
    b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
    kick(8'd255, 32'd0);
    b.in_data = 32'd1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        total++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin bad++; $display("FAIL full_count_early got v=%0h r=%0h want v=0 r=1", b.out_valid, b.in_ready); end
      end
      b.in_valid = 1'b1;
      step();
    end
    b.in_valid = 1'b0;
    total++; if (b.out_valid !== 1'b1 || b.out_data !== 32'd256) begin bad++; $display("FAIL full_count got v=%0h d=%0h want v=1 d=100", b.out_valid, b.out_data); end
    b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    kick(8'd3, 32'd77);
    b.in_valid = 1'b1; b.in_data = 32'd4;
    step(); step();
    rst = 1'b1;
    #1;
    total++; if (b.in_ready !== 1'b0 || b.out_valid !== 1'b0 || b.busy !== 1'b0 || b.out_data !== 32'h0) begin bad++; $display("FAIL mid_reset got r=%0h v=%0h busy=%0h d=%0h want all 0", b.in_ready, b.out_valid, b.busy, b.out_data); end
    step();
    rst = 1'b0;
    b.in_valid = 1'b0;
    step();
    kick(8'd0, 32'd0);
    b.in_valid = 1'b1; b.in_data = 32'd9;
    step();
    b.in_valid = 1'b0;
    total++; if (b.out_valid !== 1'b1 || b.out_data !== 32'd9) begin bad++; $display("FAIL post_reset_job got v=%0h d=%0h want v=1 d=9", b.out_valid, b.out_data); end
    b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
